instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 87 ++++++++
 tb/tb_instr_fetch_queue.sv | 135 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: keeps a small ring of {pc+4, instruction} ahead of the dispatcher,
// issuing one imem read per credit and flushing on redirect.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_rd,
  input  logic [31:0] i_imem_data,
  input  logic        i_rd_en,
  input  logic        i_jmp_valid,
  input  logic [31:0] i_jmp_addr,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc_plus_4,
  output logic        o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
  } fq_entry_t;

  fq_entry_t      buf_q [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           in_flight;
  logic [31:0]    fetch_pc, saved_pc;
  logic           issue, wr, pop;
  fq_entry_t      head;

  // An outstanding read holds a slot, so count + in_flight never exceeds DEPTH.
  always_comb begin
    issue = !i_rst && !i_jmp_valid && ((count + CW'(in_flight)) < DEPTH_C);
    wr    = in_flight && !i_jmp_valid;
    pop   = i_rd_en && (count != '0) && !i_jmp_valid;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc  <= RESET_PC;
      saved_pc  <= '0;
      in_flight <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (i_jmp_valid) begin
      fetch_pc  <= i_jmp_addr;
      in_flight <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        saved_pc <= fetch_pc;
      end
      if (wr) begin
        buf_q[wr_ptr] <= '{pc_plus_4: saved_pc + 32'd4, instr: i_imem_data};
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head          = buf_q[rd_ptr];
    o_imem_addr   = fetch_pc;
    o_imem_rd     = issue;
    o_empty       = i_rst || (count == '0);
    o_instruction = i_rst ? 32'h0 : head.instr;
    o_pc_plus_4   = i_rst ? 32'h0 : head.pc_plus_4;
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: per-cycle vector table plus a redirect/PC-wrap sequence.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, rd_en, jmp_valid;
  logic [31:0] jmp_addr, imem_data, imem_addr, instruction, pc_plus_4;
  logic        imem_rd, empty;
  int          n_cmp = 0;
  int          n_bad = 0;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_addr(imem_addr), .o_imem_rd(imem_rd), .i_imem_data(imem_data),
    .i_rd_en(rd_en), .i_jmp_valid(jmp_valid), .i_jmp_addr(jmp_addr),
    .o_instruction(instruction), .o_pc_plus_4(pc_plus_4), .o_empty(empty)
  );

  always #5 clk = ~clk;

  // Memory returns word_address*16 one cycle after the strobe; garbage otherwise.
  always @(posedge clk) imem_data <= imem_rd ? (imem_addr << 2) : 32'hDEAD_BEEF;

  typedef struct {
    bit          rst, rd_en, jmp;
    logic [31:0] ja;
    bit          e_rd, chk_addr;
    logic [31:0] e_addr;
    bit          e_empty, chk_head;
    logic [31:0] e_pc4, e_ins;
  } vec_t;

  vec_t vecs [33];

  function automatic vec_t mk(bit r, bit re, bit j, logic [31:0] ja, bit erd, bit ca,
                              logic [31:0] ea, bit ee, bit ch, logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.rst = r; v.rd_en = re; v.jmp = j; v.ja = ja;
    v.e_rd = erd; v.chk_addr = ca; v.e_addr = ea;
    v.e_empty = ee; v.chk_head = ch; v.e_pc4 = ep; v.e_ins = ei;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit re, input bit j, input logic [31:0] ja);
    @(negedge clk);
    rst = r; rd_en = re; jmp_valid = j; jmp_addr = ja;
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; rd_en = 1'b0; jmp_valid = 1'b0; jmp_addr = '0;

    //              rst re jmp ja         rd ca addr       emp ch pc4        ins
    vecs[0]  = mk(1, 0, 0, 0,          0, 0, 0,          1, 1, 0,          0);
    vecs[1]  = mk(1, 0, 0, 0,          0, 1, 0,          1, 1, 0,          0);
    vecs[2]  = mk(0, 0, 0, 0,          1, 1, 0,          1, 0, 0,          0);
    vecs[3]  = mk(0, 0, 0, 0,          1, 1, 4,          1, 0, 0,          0);
    vecs[4]  = mk(0, 0, 0, 0,          1, 1, 8,          0, 1, 4,          0);
    vecs[5]  = mk(0, 0, 0, 0,          1, 1, 12,         0, 1, 4,          0);
    vecs[6]  = mk(0, 0, 0, 0,          0, 1, 16,         0, 1, 4,          0);
    vecs[7]  = mk(0, 0, 0, 0,          0, 1, 16,         0, 1, 4,          0);
    vecs[8]  = mk(0, 1, 0, 0,          0, 1, 16,         0, 1, 4,          0);
    vecs[9]  = mk(0, 0, 0, 0,          1, 1, 16,         0, 1, 8,          16);
    vecs[10] = mk(0, 0, 0, 0,          0, 1, 20,         0, 1, 8,          16);
    vecs[11] = mk(0, 1, 0, 0,          0, 1, 20,         0, 1, 8,          16);
    vecs[12] = mk(0, 1, 0, 0,          1, 1, 20,         0, 1, 12,         32);
    vecs[13] = mk(0, 1, 0, 0,          1, 1, 24,         0, 1, 16,         48);
    vecs[14] = mk(0, 1, 0, 0,          1, 1, 28,         0, 1, 20,         64);
    vecs[15] = mk(0, 1, 0, 0,          1, 1, 32,         0, 1, 24,         80);
    vecs[16] = mk(0, 0, 1, 32'h100,    0, 1, 36,         0, 1, 28,         96);
    vecs[17] = mk(0, 0, 0, 0,          1, 1, 32'h100,    1, 0, 0,          0);
    vecs[18] = mk(0, 0, 0, 0,          1, 1, 32'h104,    1, 0, 0,          0);
    vecs[19] = mk(0, 1, 1, 32'h200,    0, 1, 32'h108,    0, 1, 32'h104,    32'h400);
    vecs[20] = mk(0, 1, 0, 0,          1, 1, 32'h200,    1, 0, 0,          0);
    vecs[21] = mk(0, 0, 0, 0,          1, 1, 32'h204,    1, 0, 0,          0);
    vecs[22] = mk(0, 0, 0, 0,          1, 1, 32'h208,    0, 1, 32'h204,    32'h800);
    vecs[23] = mk(0, 0, 0, 0,          1, 1, 32'h20c,    0, 1, 32'h204,    32'h800);
    vecs[24] = mk(1, 0, 0, 0,          0, 0, 0,          1, 1, 0,          0);
    vecs[25] = mk(0, 0, 0, 0,          1, 1, 0,          1, 0, 0,          0);
    vecs[26] = mk(0, 1, 0, 0,          1, 1, 4,          1, 0, 0,          0);
    vecs[27] = mk(0, 1, 0, 0,          1, 1, 8,          0, 1, 4,          0);
    vecs[28] = mk(0, 1, 0, 0,          1, 1, 12,         0, 1, 8,          16);
    vecs[29] = mk(0, 1, 0, 0,          1, 1, 16,         0, 1, 12,         32);
    vecs[30] = mk(0, 1, 0, 0,          1, 1, 20,         0, 1, 16,         48);
    vecs[31] = mk(0, 1, 0, 0,          1, 1, 24,         0, 1, 20,         64);
    vecs[32] = mk(0, 0, 0, 0,          1, 1, 28,         0, 1, 24,         80);

    for (int i = 0; i < 33; i++) begin
      drive(vecs[i].rst, vecs[i].rd_en, vecs[i].jmp, vecs[i].ja);
      chk("imem_rd", i, 32'(imem_rd), 32'(vecs[i].e_rd));
      chk("empty",   i, 32'(empty),   32'(vecs[i].e_empty));
      if (vecs[i].chk_addr) chk("imem_addr", i, imem_addr, vecs[i].e_addr);
      if (vecs[i].chk_head) begin
        chk("pc_plus_4",   i, pc_plus_4,   vecs[i].e_pc4);
        chk("instruction", i, instruction, vecs[i].e_ins);
      end
    end

    // Redirect near the top of the address space: fetch PC must wrap to 0.
    drive(0, 0, 1, 32'hFFFF_FFF8);
    chk("flush_rd", 100, 32'(imem_rd), 32'd0);
    drive(0, 0, 0, 0);
    chk("wrap_rd0",   101, 32'(imem_rd), 32'd1);
    chk("wrap_addr0", 101, imem_addr, 32'hFFFF_FFF8);
    chk("wrap_empty", 101, 32'(empty), 32'd1);
    n = 0;
    while (empty && n < 10) begin
      drive(0, 0, 0, 0);
      n++;
    end
    chk("fill_latency", 102, n, 2);
    chk("wrap_addr2",   103, imem_addr, 32'h0);
    chk("wrap_pc4a",    103, pc_plus_4, 32'hFFFF_FFFC);
    chk("wrap_insa",    103, instruction, 32'hFFFF_FFE0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("wrap_pc4b",    104, pc_plus_4, 32'h0);
    chk("wrap_insb",    104, instruction, 32'hFFFF_FFF0);
    drive(0, 1, 0, 0);
    chk("wrap_pc4c",    105, pc_plus_4, 32'h4);
    chk("wrap_insc",    105, instruction, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
